// File: rtl/output_capture.sv
// Triggered capture of a sampled vector into a first-word-fall-through FIFO.
// Arm, wait for a masked match, then store a fixed number of samples.
module output_capture #(
  parameter int unsigned vector_size = 32,
  parameter int unsigned fifo_depth  = 512,
  parameter int unsigned count_w     = 10
) (
  input  logic                   clk,
  input  logic                   logic_reset_n,
  input  logic [vector_size-1:0] din,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   clear,
  input  logic [vector_size-1:0] trig_mask,
  input  logic [vector_size-1:0] trig_value,
  input  logic [count_w-1:0]     capture_len,
  output logic                   rd_valid,
  output logic [vector_size-1:0] rd_data,
  input  logic                   rd_ready,
  output logic [1:0]             state,
  output logic [count_w-1:0]     fifo_count,
  output logic                   overflow
);

  localparam int unsigned ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   live;
  logic [count_w-1:0]     len_q;
  logic [vector_size-1:0] mask_q;
  logic [vector_size-1:0] value_q;
  logic [count_w-1:0]     cnt_q;
  logic [count_w-1:0]     cnt_d;
  logic                   latch_c;
  logic                   wr_req_c;
  logic                   trig_hit_c;
  logic [count_w-1:0]     len_eff_c;

  logic [vector_size-1:0] mem [fifo_depth];
  logic [ptr_w-1:0]       wr_ptr;
  logic [ptr_w-1:0]       rd_ptr;
  logic [ptr_w-1:0]       rd_ptr_nx_c;
  logic                   pop_c;
  logic                   full_c;
  logic                   wr_en_c;
  logic                   drop_c;
  logic [count_w-1:0]     count_d;
  logic [vector_size-1:0] head_d;

  assign state      = state_q;
  assign trig_hit_c = ((din & mask_q) == (value_q & mask_q));
  assign len_eff_c  = (capture_len == '0) ? count_w'(1) : capture_len;

  // Capture sequencing: trigger search, sample counting, write requests.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_c  = 1'b0;
    wr_req_c = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d = ARMED;
            latch_c = 1'b1;
            cnt_d   = '0;
          end
        end
        ARMED: begin
          if (trig_hit_c) begin
            wr_req_c = 1'b1;
            cnt_d    = count_w'(1);
            state_d  = (len_q == count_w'(1)) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          wr_req_c = 1'b1;
          cnt_d    = cnt_q + count_w'(1);
          if (cnt_d == len_q) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO control: a full FIFO only accepts a write when the head leaves the same edge.
  always_comb begin
    pop_c       = rd_valid & rd_ready;
    full_c      = (fifo_count == count_w'(fifo_depth));
    wr_en_c     = wr_req_c & (~full_c | pop_c);
    drop_c      = wr_req_c & full_c & ~pop_c;
    rd_ptr_nx_c = rd_ptr + ptr_w'(1);
    count_d     = fifo_count;
    case ({wr_en_c, pop_c})
      2'b10:   count_d = fifo_count + count_w'(1);
      2'b01:   count_d = fifo_count - count_w'(1);
      default: count_d = fifo_count;
    endcase
  end

  // Next head word for the registered fall-through output.
  always_comb begin
    head_d = rd_data;
    if (wr_en_c && ((fifo_count == '0) || (pop_c && (fifo_count == count_w'(1))))) begin
      head_d = din;
    end else if (pop_c && (fifo_count > count_w'(1))) begin
      head_d = mem[rd_ptr_nx_c];
    end
  end

  // Control and status registers; nothing moves until the edge after reset release.
  always_ff @(posedge clk or negedge logic_reset_n) begin
    if (!logic_reset_n) begin
      live       <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= count_w'(1);
      mask_q     <= '0;
      value_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      overflow   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (live) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (latch_c) begin
          len_q   <= len_eff_c;
          mask_q  <= trig_mask;
          value_q <= trig_value;
        end
        if (clear) begin
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          fifo_count <= '0;
          rd_valid   <= 1'b0;
          overflow   <= 1'b0;
        end else begin
          if (wr_en_c) wr_ptr <= wr_ptr + ptr_w'(1);
          if (pop_c) rd_ptr <= rd_ptr_nx_c;
          fifo_count <= count_d;
          rd_valid   <= (count_d != '0);
          rd_data    <= head_d;
          if (drop_c) overflow <= 1'b1;
        end
      end
    end
  end

  // Sample storage; no reset so it can map onto a RAM.
  always_ff @(posedge clk) begin
    if (live && wr_en_c && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: tb/tb_output_capture.sv
// Randomized and directed bench for output_capture against a queue-based reference model.
module tb_output_capture;

  localparam int unsigned VS    = 32;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned CW    = 10;

  logic          clk = 1'b0;
  logic          logic_reset_n;
  logic [VS-1:0] din;
  logic          arm;
  logic          abort;
  logic          clear;
  logic [VS-1:0] trig_mask;
  logic [VS-1:0] trig_value;
  logic [CW-1:0] capture_len;
  logic          rd_valid;
  logic [VS-1:0] rd_data;
  logic          rd_ready;
  logic [1:0]    state;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  always #5 clk = ~clk;

  output_capture #(
    .vector_size(VS),
    .fifo_depth (DEPTH),
    .count_w    (CW)
  ) dut (
    .clk          (clk),
    .logic_reset_n(logic_reset_n),
    .din          (din),
    .arm          (arm),
    .abort        (abort),
    .clear        (clear),
    .trig_mask    (trig_mask),
    .trig_value   (trig_value),
    .capture_len  (capture_len),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .state        (state),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: capture state, stored words in arrival order, sticky drop flag.
  int            m_state;
  logic [VS-1:0] m_q[$];
  bit            m_ovf;
  int            m_len;
  logic [VS-1:0] m_mask;
  logic [VS-1:0] m_val;
  int            m_cnt;
  bit            m_live;

  task automatic model_reset();
    m_state = 0;
    m_q.delete();
    m_ovf  = 1'b0;
    m_len  = 1;
    m_mask = '0;
    m_val  = '0;
    m_cnt  = 0;
    m_live = 1'b0;
  endtask

  task automatic model_step();
    bit pop;
    bit wr;
    int ns;
    pop = (m_q.size() != 0) && rd_ready;
    wr  = 1'b0;
    ns  = m_state;
    if (abort) begin
      ns = 0;
    end else begin
      case (m_state)
        0, 3: if (arm) begin
          ns     = 1;
          m_len  = (capture_len == '0) ? 1 : int'(capture_len);
          m_mask = trig_mask;
          m_val  = trig_value;
          m_cnt  = 0;
        end
        1: if (((din ^ m_val) & m_mask) == '0) begin
          wr    = 1'b1;
          m_cnt = 1;
          ns    = (m_cnt == m_len) ? 3 : 2;
        end
        2: begin
          wr    = 1'b1;
          m_cnt = m_cnt + 1;
          if (m_cnt == m_len) ns = 3;
        end
        default: ;
      endcase
    end
    if (clear) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (wr) begin
        if (m_q.size() < DEPTH || pop) m_q.push_back(din);
        else m_ovf = 1'b1;
      end
      if (pop) void'(m_q.pop_front());
    end
    m_state = ns;
  endtask

  task automatic compare_all();
    check("state", 32'(state), 32'(m_state));
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() != 0) check("rd_data", rd_data, m_q[0]);
  endtask

  // One clock: drive at negedge, advance the model, sample just after the rising edge.
  task automatic cycle(input bit a, input bit ab, input bit cl, input logic [VS-1:0] d,
                       input bit rr, input bit rst);
    @(negedge clk);
    arm           = a;
    abort         = ab;
    clear         = cl;
    din           = d;
    rd_ready      = rr;
    logic_reset_n = rst;
    if (!rst) model_reset();
    else if (!m_live) m_live = 1'b1;
    else model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_trig(input logic [VS-1:0] mk, input logic [VS-1:0] vl, input int ln);
    trig_mask   = mk;
    trig_value  = vl;
    capture_len = CW'(ln);
  endtask

  initial begin
    logic_reset_n = 1'b0;
    din = '0; arm = 0; abort = 0; clear = 0; rd_ready = 0;
    set_trig('0, '0, 0);
    model_reset();
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    cycle(0, 0, 0, '0, 0, 0);
    cycle(0, 0, 0, '0, 0, 0);
    cycle(1, 0, 0, '0, 0, 1);
    check("dead_edge_state", 32'(state), 32'd0);

    // Masked trigger on a counting input.
    set_trig(32'hFF, 32'h05, 4);
    cycle(1, 0, 0, '0, 0, 1);
    check("t039_armed", 32'(state), 32'd1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, VS'(i), 0, 1);
    check("t039_state", 32'(state), 32'd3);
    check("t039_count", 32'(fifo_count), 32'd4);
    check("t039_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("t039_data", rd_data, 32'(5 + k));
      cycle(0, 0, 0, '0, 1, 1);
    end
    check("t039_drained", 32'(rd_valid), 32'd0);

    // Zero mask and zero length: one sample from the first armed cycle.
    set_trig('0, 32'h1234, 0);
    cycle(1, 0, 0, '0, 0, 1);
    check("t040_armed", 32'(state), 32'd1);
    cycle(0, 0, 0, 32'hABCD, 0, 1);
    check("t040_state", 32'(state), 32'd3);
    check("t040_count", 32'(fifo_count), 32'd1);
    check("t040_data", rd_data, 32'hABCD);
    cycle(0, 0, 0, 32'h5555, 0, 1);
    check("t040_hold", 32'(fifo_count), 32'd1);
    cycle(0, 0, 0, '0, 1, 1);

    // Overflow with no consumer.
    cycle(0, 0, 1, '0, 0, 1);
    set_trig(32'hFF, 32'h07, 520);
    cycle(1, 0, 0, '0, 0, 1);
    for (int i = 0; i < 600; i++) cycle(0, 0, 0, VS'(i), 0, 1);
    check("t041_count", 32'(fifo_count), 32'd512);
    check("t041_ovf", 32'(overflow), 32'd1);
    check("t041_data", rd_data, 32'd7);
    check("t041_state", 32'(state), 32'd3);

    // Full FIFO with a concurrent consumer never drops.
    cycle(0, 0, 1, '0, 0, 1);
    check("t042_cleared_ovf", 32'(overflow), 32'd0);
    set_trig('0, '0, 512);
    cycle(1, 0, 0, '0, 0, 1);
    for (int i = 0; i < 513; i++) cycle(0, 0, 0, VS'(i), 0, 1);
    check("t042_full", 32'(fifo_count), 32'd512);
    set_trig('0, '0, 100);
    cycle(1, 0, 0, '0, 0, 1);
    for (int i = 0; i < 100; i++) cycle(0, 0, 0, VS'($urandom), 1, 1);
    check("t042_count", 32'(fifo_count), 32'd512);
    check("t042_ovf", 32'(overflow), 32'd0);
    check("t042_state", 32'(state), 32'd3);
    check("t042_head", rd_data, 32'd100);

    // Abort mid-capture keeps stored words; clear flushes them.
    cycle(0, 0, 1, '0, 0, 1);
    set_trig('0, '0, 10);
    cycle(1, 0, 0, '0, 0, 1);
    cycle(0, 0, 0, 32'd1, 0, 1);
    cycle(0, 0, 0, 32'd2, 0, 1);
    cycle(0, 1, 0, 32'd3, 0, 1);
    check("t043_state", 32'(state), 32'd0);
    check("t043_count", 32'(fifo_count), 32'd2);
    cycle(0, 0, 1, '0, 0, 1);
    check("t043_clear_count", 32'(fifo_count), 32'd0);
    check("t043_clear_valid", 32'(rd_valid), 32'd0);

    // Asynchronous reset during capture, checked before any clock edge.
    cycle(1, 0, 0, '0, 0, 1);
    cycle(0, 0, 0, 32'd9, 0, 1);
    cycle(0, 0, 0, 32'd10, 0, 1);
    check("t044_pre_state", 32'(state), 32'd2);
    logic_reset_n = 1'b0;
    model_reset();
    #1;
    check("t044_state", 32'(state), 32'd0);
    check("t044_count", 32'(fifo_count), 32'd0);
    check("t044_valid", 32'(rd_valid), 32'd0);
    check("t044_data", rd_data, 32'd0);
    cycle(0, 0, 0, '0, 0, 0);
    cycle(1, 0, 0, '0, 0, 1);
    check("t044_dead_edge", 32'(state), 32'd0);

    // Random traffic with short captures and frequent consumption.
    for (int i = 0; i < 4000; i++) begin
      set_trig(VS'($urandom_range(0, 15)), VS'($urandom_range(0, 15)), int'($urandom_range(0, 12)));
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0,
            VS'($urandom_range(0, 31)), $urandom_range(0, 3) != 0, $urandom_range(0, 999) != 0);
    end

    // Random traffic with long captures and a slow consumer to reach full.
    for (int i = 0; i < 6000; i++) begin
      set_trig(VS'($urandom_range(0, 3)), VS'($urandom_range(0, 3)), int'($urandom_range(0, 1023)));
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 499) == 0, $urandom_range(0, 999) == 0,
            VS'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 2999) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_capture.md
OUTPUT_CAPTURE -- requirements
Module: output_capture

Interface
REQ-001 The module SHALL have parameter vector_size, default 32, giving the width of the captured vector.
REQ-002 The module SHALL have parameter fifo_depth, default 512, giving the capture FIFO depth in words (power of two).
REQ-003 The module SHALL have parameter count_w, default 10, giving the width of capture_len and fifo_count (log2(fifo_depth)+1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 logic_reset_n  input  1  reset; asynchronous, active-low.
REQ-006 din  input  vector_size  DUT output vector, sampled every cycle.
REQ-007 arm  input  1  single-cycle pulse; starts a capture.
REQ-008 abort  input  1  returns the FSM to IDLE from any state.
REQ-009 clear  input  1  flushes FIFO and clears overflow.
REQ-010 trig_mask  input  vector_size  bits of din compared for trigger.
REQ-011 trig_value  input  vector_size  trigger compare value.
REQ-012 capture_len  input  count_w  samples to store per capture, including the trigger sample.
REQ-013 rd_valid  output  1  FIFO head is valid.
REQ-014 rd_data  output  vector_size  FIFO head (first-word fall-through).
REQ-015 rd_ready  input  1  consumer accepts the head.
REQ-016 state  output  2  FSM state: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-017 fifo_count  output  count_w  words currently stored.
REQ-018 overflow  output  1  sticky; a sample was dropped because the FIFO was full.

Function
REQ-019 On arm in IDLE or DONE, the FSM SHALL enter ARMED on the next edge and latch capture_len, trig_mask and trig_value; a latched length of 0 SHALL be treated as 1.
REQ-020 arm SHALL be ignored in ARMED and CAPTURE.
REQ-021 In ARMED, when (din & mask) == (value & mask) using the latched values, din SHALL be written that edge and the FSM SHALL enter CAPTURE, or DONE if length == 1.
REQ-022 A latched mask of 0 SHALL trigger on the first ARMED cycle.
REQ-023 In CAPTURE, din SHALL be written every cycle.
REQ-024 An internal sample counter SHALL count every write attempt, including dropped ones.
REQ-025 The FSM SHALL enter DONE on the edge where the counter reaches the latched length; exactly length samples are attempted.
REQ-026 DONE SHALL hold until arm or abort.
REQ-027 FIFO contents SHALL be retained across re-arm.
REQ-028 Write latency: a sample written at edge N SHALL be visible as rd_valid=1 with its value on rd_data after edge N, if the FIFO was empty.
REQ-029 rd_valid SHALL equal (fifo_count != 0), and rd_data SHALL be the oldest word.
REQ-030 A pop SHALL occur on any edge with rd_valid && rd_ready, in any FSM state.
REQ-031 When full, a write SHALL be accepted only if a pop occurs on the same edge; otherwise the sample is dropped, overflow is set, and the counter still advances.
REQ-032 A simultaneous write and pop on an empty FIFO SHALL write only (nothing to pop); fifo_count SHALL be unchanged on a simultaneous write and pop when non-empty.
REQ-033 Read and write pointers SHALL wrap modulo fifo_depth; fifo_count SHALL range 0..fifo_depth.
REQ-034 abort SHALL force IDLE on the next edge, suppress any write that edge, and take priority over arm; the FIFO SHALL be retained.
REQ-035 clear SHALL zero the pointers, fifo_count and overflow on the next edge, discarding any same-edge write or pop; the FSM SHALL be unaffected.

Reset
REQ-036 While logic_reset_n=0, all outputs and registers SHALL take their reset values asynchronously: state=IDLE, fifo_count=0, rd_valid=0, overflow=0, rd_data=0, pointers and counter=0.
REQ-037 Deassertion SHALL be sampled synchronously, with the first state change possible on the second clk edge after the rise.
REQ-038 Reset mid-capture SHALL discard all FIFO contents.

Verification
REQ-039 Trigger capture: mask=0xFF, value=0x05, len=4, din counting 0,1,2,... from ARMED -> FIFO holds 5,6,7,8; state DONE; overflow=0.
REQ-040 Immediate trigger: mask=0, len=0 -> exactly one word stored (the din of the first ARMED cycle); state goes ARMED->DONE.
REQ-041 Overflow: fifo_depth=512, len=520, rd_ready=0 -> fifo_count=512, overflow=1, DONE after 520 cycles in capture; rd_data=the trigger sample.
REQ-042 Full with concurrent pop: FIFO full, rd_ready=1 during capture -> no drops, fifo_count stays 512, overflow=0.
REQ-043 Abort/clear: abort at CAPTURE cycle 2 of len=10 -> IDLE, fifo_count=2; then clear -> fifo_count=0, rd_valid=0.
REQ-044 Async reset: logic_reset_n low mid-CAPTURE with no clk edge -> state=0, fifo_count=0, rd_valid=0 immediately.
